// File: rtl/sim_mem_io_ctrl_if.sv
// -----------------------------------------------------------------------------
// sim_mem_io_ctrl_if
//   Bundles the CPU byte bus and the output-console handshake used by
//   sim_mem_io_ctrl.
//
//   CPU side   : mem_a / mem_wr / mem_dout  (CPU -> model)
//                mem_din / io_buffer_full   (model -> CPU)
//   Console    : io_valid / io_data         (model -> consumer)
//                io_ready                   (consumer -> model)
//
//   modport master : the CPU / bench side that drives addresses and accepts
//                    console bytes.
//   modport slave  : the memory / I/O model.
// -----------------------------------------------------------------------------
interface sim_mem_io_ctrl_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        io_valid;
    logic [7:0]  io_data;
    logic        io_ready;

    modport master (
        output mem_a, mem_wr, mem_dout, io_ready,
        input  mem_din, io_buffer_full, io_valid, io_data
    );

    modport slave (
        input  mem_a, mem_wr, mem_dout, io_ready,
        output mem_din, io_buffer_full, io_valid, io_data
    );
endinterface

// File: rtl/sim_mem_io_ctrl.sv
// -----------------------------------------------------------------------------
// sim_mem_io_ctrl
//   Byte-serial memory and I/O responder for the CPU bench.  Addresses below
//   IO_BASE hit a 2^ADDR_WIDTH byte RAM; anything at or above IO_BASE is I/O.
//   Writes to IO_BASE are queued in an output FIFO that drains to a console
//   handshake; a write to IO_BASE+4 raises a sticky halt flag.
//
// Ports
//   clk_in     : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : global enable; 0 freezes CPU-side activity (FIFO drain and
//                preload keep running)
//   bus        : CPU bus + console handshake (slave modport)
//   halt       : sticky, set by a write to IO_BASE+4
//   overflow   : sticky, set by a push that found the FIFO full
//   load_en    : bench preload strobe (wins over a same-cycle CPU RAM write)
//   load_addr  : preload address
//   load_data  : preload byte
// -----------------------------------------------------------------------------
module sim_mem_io_ctrl #(
    parameter int          ADDR_WIDTH = 17,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          READ_LAT   = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  en,
    sim_mem_io_ctrl_if.slave      bus,
    output logic                  halt,
    output logic                  overflow,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [7:0]            load_data
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = PW + 1;
    localparam int          RAM_WORDS = 2 ** ADDR_WIDTH;
    localparam logic [31:0] HALT_ADDR = IO_BASE + 32'd4;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                  ram_sel;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  cpu_ram_we;
    logic                  rd_en;
    logic                  push_req;
    logic                  halt_req;

    assign ram_sel    = (bus.mem_a < IO_BASE);
    assign ram_idx    = bus.mem_a[ADDR_WIDTH-1:0];
    assign cpu_ram_we = en && bus.mem_wr && ram_sel && !load_en;
    assign rd_en      = en && !bus.mem_wr;
    assign push_req   = en && bus.mem_wr && !ram_sel && (bus.mem_a == IO_BASE);
    assign halt_req   = en && bus.mem_wr && !ram_sel && (bus.mem_a == HALT_ADDR);

    // ------------------------------------------------------------------
    // RAM: single write port (preload has priority) and a registered read.
    // Non-blocking update gives old-data on a same-address read/write.
    // ------------------------------------------------------------------
    logic [7:0] ram [0:RAM_WORDS-1];
    logic [7:0] ram_q_reg;

    always_ff @(posedge clk_in) begin
        if (load_en) begin
            ram[load_addr] <= load_data;
        end else if (cpu_ram_we) begin
            ram[ram_idx] <= bus.mem_dout;
        end
        if (rd_en) begin
            ram_q_reg <= ram[ram_idx];
        end
    end

    // The RAM output register carries no reset, so two reset-cleared flags
    // qualify it: rd_live_reg says a read has been captured since reset and
    // rd_io_reg says that read targeted the I/O window (which reads as 0).
    // Together they form the first stage of the read pipeline.
    logic       rd_live_reg;
    logic       rd_io_reg;
    logic [7:0] stage0;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rd_live_reg <= 1'b0;
            rd_io_reg   <= 1'b0;
        end else if (rd_en) begin
            rd_live_reg <= 1'b1;
            rd_io_reg   <= !ram_sel;
        end
    end

    assign stage0 = (rd_live_reg && !rd_io_reg) ? ram_q_reg : 8'h00;

    // Remaining READ_LAT-1 stages advance on every enabled cycle and
    // freeze with en low.
    generate
        if (READ_LAT == 1) begin : g_lat1
            assign bus.mem_din = stage0;
        end else begin : g_latn
            logic [7:0] pipe_reg [1:READ_LAT-1];

            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 1; i < READ_LAT; i++) begin
                        pipe_reg[i] <= 8'h00;
                    end
                end else if (en) begin
                    pipe_reg[1] <= stage0;
                    for (int i = 2; i < READ_LAT; i++) begin
                        pipe_reg[i] <= pipe_reg[i-1];
                    end
                end
            end

            assign bus.mem_din = pipe_reg[READ_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;
    logic          io_buffer_full_reg;
    logic          halt_reg;
    logic          overflow_reg;

    assign fifo_full = (count_reg == CW'(FIFO_DEPTH));
    assign pop       = (count_reg != '0) && bus.io_ready;
    // A push into a full FIFO still lands if the head leaves this cycle.
    assign push_ok   = push_req && (!fifo_full || pop);

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push_ok && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= bus.mem_dout;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
            io_buffer_full_reg <= 1'b0;
            halt_reg           <= 1'b0;
            overflow_reg       <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
            // Flag one entry early so a store already in flight still fits.
            io_buffer_full_reg <= (count_next >= CW'(FIFO_DEPTH - 1));
            if (push_req && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
            if (halt_req) begin
                halt_reg <= 1'b1;
            end
        end
    end

    // Head byte is masked while empty so the console sees 0 after reset.
    assign bus.io_valid       = (count_reg != '0);
    assign bus.io_data        = (count_reg != '0) ? fifo_mem[rd_ptr_reg] : 8'h00;
    assign bus.io_buffer_full = io_buffer_full_reg;
    assign halt               = halt_reg;
    assign overflow           = overflow_reg;

endmodule
